// File: rtl/model_trainer_lstm_pkg.sv
// Shared types and fixed-point constants for the LSTM trainer stages.
// No latency and no flow control: types, constants and helper functions only.
package model_trainer_lstm_pkg;

  localparam int FRACTION_SIZE_DEFAULT = 32;
  localparam int SAT_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE,
    INPUT,
    DRAIN,
    ENDER
  } sgd_state_t;

  // Wide enough for any callers' product width; callers cast down to their own width.
  function automatic logic signed [SAT_WIDTH-1:0] sat_max(input int width);
    logic signed [SAT_WIDTH-1:0] one;
    one = SAT_WIDTH'(1);
    return (one <<< (width - 1)) - one;
  endfunction

  function automatic logic signed [SAT_WIDTH-1:0] sat_min(input int width);
    logic signed [SAT_WIDTH-1:0] one;
    one = SAT_WIDTH'(1);
    return -(one <<< (width - 1));
  endfunction

endpackage

// File: rtl/ntm_scalar_fixed_multiplier_saturate.sv
// Signed fixed-point a*b with floor rescale and saturation to DATA_SIZE.
// One-cycle latency (registered product); no backpressure, en gates the product register.
module ntm_scalar_fixed_multiplier_saturate
  import model_trainer_lstm_pkg::*;
#(
  parameter int DATA_SIZE     = 64,
  parameter int FRACTION_SIZE = FRACTION_SIZE_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic signed [DATA_SIZE-1:0] a,
  input  logic signed [DATA_SIZE-1:0] b,
  output logic signed [DATA_SIZE-1:0] q
);

  localparam int PW = 2 * DATA_SIZE;
  localparam logic signed [PW-1:0] P_MAX = PW'(sat_max(DATA_SIZE));
  localparam logic signed [PW-1:0] P_MIN = PW'(sat_min(DATA_SIZE));
  localparam logic signed [DATA_SIZE-1:0] D_MAX = DATA_SIZE'(sat_max(DATA_SIZE));
  localparam logic signed [DATA_SIZE-1:0] D_MIN = DATA_SIZE'(sat_min(DATA_SIZE));

  logic signed [PW-1:0] p;
  logic signed [PW-1:0] p_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
    end else if (en) begin
      p <= PW'(a) * PW'(b);
    end
  end

  // Arithmetic shift rounds toward minus infinity.
  assign p_shift = p >>> FRACTION_SIZE;

  always_comb begin
    q = p_shift[DATA_SIZE-1:0];
    if (p_shift > P_MAX) begin
      q = D_MAX;
    end else if (p_shift < P_MIN) begin
      q = D_MIN;
    end
  end

endmodule

// File: rtl/model_trainer_lstm_sgd_update.sv
// Element-wise SGD update W - eta*D over a SIZE_I x SIZE_J matrix stream, saturating.
// Latency 2 cycles strobe-to-output, 1 element/cycle; no backpressure, READY pulses after the last output.
module model_trainer_lstm_sgd_update
  import model_trainer_lstm_pkg::*;
#(
  parameter int DATA_SIZE     = 64,
  parameter int CONTROL_SIZE  = 64,
  parameter int FRACTION_SIZE = FRACTION_SIZE_DEFAULT
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [CONTROL_SIZE-1:0] SIZE_I_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_J_IN,
  input  logic [DATA_SIZE-1:0]    LEARNING_RATE_IN,
  input  logic                    DATA_IN_I_ENABLE,
  input  logic                    DATA_IN_J_ENABLE,
  input  logic [DATA_SIZE-1:0]    W_IN,
  input  logic [DATA_SIZE-1:0]    D_IN,
  output logic                    DATA_OUT_I_ENABLE,
  output logic                    DATA_OUT_J_ENABLE,
  output logic [DATA_SIZE-1:0]    W_OUT
);

  localparam int RW = DATA_SIZE + 1;
  localparam logic signed [RW-1:0] R_MAX = RW'(sat_max(DATA_SIZE));
  localparam logic signed [RW-1:0] R_MIN = RW'(sat_min(DATA_SIZE));
  localparam logic signed [DATA_SIZE-1:0] D_MAX = DATA_SIZE'(sat_max(DATA_SIZE));
  localparam logic signed [DATA_SIZE-1:0] D_MIN = DATA_SIZE'(sat_min(DATA_SIZE));

  sgd_state_t                  state;
  logic [CONTROL_SIZE-1:0]     size_i, size_j, cnt_i, cnt_j;
  logic signed [DATA_SIZE-1:0] eta, w1, q1, r_sat;
  logic signed [RW-1:0]        r;
  logic                        accept, v1, first1;
  logic                        unused_row_flag;

  // Row starts are derived from the column counter, so the upstream row flag is not needed.
  assign unused_row_flag = DATA_IN_I_ENABLE;
  assign accept = (state == INPUT) && DATA_IN_J_ENABLE;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      size_i <= '0;
      size_j <= '0;
      cnt_i  <= '0;
      cnt_j  <= '0;
      eta    <= '0;
      READY  <= 1'b0;
    end else begin
      READY <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            size_i <= SIZE_I_IN;
            size_j <= SIZE_J_IN;
            eta    <= LEARNING_RATE_IN;
            cnt_i  <= '0;
            cnt_j  <= '0;
            state  <= (SIZE_I_IN != '0 && SIZE_J_IN != '0) ? INPUT : ENDER;
          end
        end
        INPUT: begin
          if (DATA_IN_J_ENABLE) begin
            if (cnt_j == size_j - CONTROL_SIZE'(1)) begin
              cnt_j <= '0;
              if (cnt_i == size_i - CONTROL_SIZE'(1)) begin
                state <= DRAIN;
              end else begin
                cnt_i <= cnt_i + CONTROL_SIZE'(1);
              end
            end else begin
              cnt_j <= cnt_j + CONTROL_SIZE'(1);
            end
          end
        end
        // Stage 1 holds the final element here and always empties into the output stage.
        DRAIN: state <= ENDER;
        ENDER: begin
          READY <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ntm_scalar_fixed_multiplier_saturate #(
    .DATA_SIZE    (DATA_SIZE),
    .FRACTION_SIZE(FRACTION_SIZE)
  ) u_mul (
    .clk(CLK),
    .rst(RST),
    .en (accept),
    .a  (eta),
    .b  (D_IN),
    .q  (q1)
  );

  // One guard bit keeps W - q exact before clamping.
  assign r = RW'(w1) - RW'(q1);

  always_comb begin
    r_sat = r[DATA_SIZE-1:0];
    if (r > R_MAX) begin
      r_sat = D_MAX;
    end else if (r < R_MIN) begin
      r_sat = D_MIN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v1                <= 1'b0;
      first1            <= 1'b0;
      w1                <= '0;
      DATA_OUT_J_ENABLE <= 1'b0;
      DATA_OUT_I_ENABLE <= 1'b0;
      W_OUT             <= '0;
    end else begin
      v1                <= accept;
      first1            <= accept && (cnt_j == '0);
      DATA_OUT_J_ENABLE <= v1;
      DATA_OUT_I_ENABLE <= v1 && first1;
      if (accept) begin
        w1 <= W_IN;
      end
      if (v1) begin
        W_OUT <= r_sat;
      end
    end
  end

endmodule

// File: tb/tb_model_trainer_lstm_sgd_update.sv
// Randomized bench for the SGD update stage against a per-cycle expectation timeline.
// Expectations come from a job-level model (element count, row position) and longint arithmetic.
module tb_model_trainer_lstm_sgd_update;

  localparam int DW   = 32;
  localparam int CW   = 32;
  localparam int FW   = 16;
  localparam int NCYC = 4096;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          READY;
  logic [CW-1:0] SIZE_I_IN = '0;
  logic [CW-1:0] SIZE_J_IN = '0;
  logic [DW-1:0] LEARNING_RATE_IN = '0;
  logic          DATA_IN_I_ENABLE = 1'b0;
  logic          DATA_IN_J_ENABLE = 1'b0;
  logic [DW-1:0] W_IN = '0;
  logic [DW-1:0] D_IN = '0;
  logic          DATA_OUT_I_ENABLE;
  logic          DATA_OUT_J_ENABLE;
  logic [DW-1:0] W_OUT;

  always #5 CLK = ~CLK;

  model_trainer_lstm_sgd_update #(
    .DATA_SIZE    (DW),
    .CONTROL_SIZE (CW),
    .FRACTION_SIZE(FW)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .START            (START),
    .READY            (READY),
    .SIZE_I_IN        (SIZE_I_IN),
    .SIZE_J_IN        (SIZE_J_IN),
    .LEARNING_RATE_IN (LEARNING_RATE_IN),
    .DATA_IN_I_ENABLE (DATA_IN_I_ENABLE),
    .DATA_IN_J_ENABLE (DATA_IN_J_ENABLE),
    .W_IN             (W_IN),
    .D_IN             (D_IN),
    .DATA_OUT_I_ENABLE(DATA_OUT_I_ENABLE),
    .DATA_OUT_J_ENABLE(DATA_OUT_J_ENABLE),
    .W_OUT            (W_OUT)
  );

  int cyc = 0;
  always @(posedge CLK) cyc++;

  bit            exp_vld  [NCYC];
  bit            exp_first[NCYC];
  bit            exp_rdy  [NCYC];
  logic [DW-1:0] exp_w    [NCYC];

  bit            in_input  = 1'b0;
  int            idle_from = 0;
  int            idx       = 0;
  int            total     = 0;
  int            sj_m      = 1;
  logic [DW-1:0] eta_m     = '0;

  int            n_vec  = 0;
  int            n_bad  = 0;
  bit            mon_on = 1'b1;
  logic [DW-1:0] w_hold = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] sgd_ref(input logic [DW-1:0] w, input logic [DW-1:0] d,
                                            input logic [DW-1:0] eta);
    longint hi = 64'sd2147483647;
    longint lo = -64'sd2147483648;
    longint e, dd, p, q, r;
    e  = $signed(eta);
    dd = $signed(d);
    p  = e * dd;
    q  = p >>> FW;
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    r = longint'($signed(w)) - q;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r[DW-1:0];
  endfunction

  always @(negedge CLK) begin
    if (mon_on && cyc < NCYC) begin
      if (RST) w_hold = '0;
      else if (exp_vld[cyc]) w_hold = exp_w[cyc];
      check("ready", 64'(READY), 64'(exp_rdy[cyc]));
      check("out_j_en", 64'(DATA_OUT_J_ENABLE), 64'(exp_vld[cyc]));
      check("out_i_en", 64'(DATA_OUT_I_ENABLE), 64'(exp_vld[cyc] & exp_first[cyc]));
      check("w_out", 64'(W_OUT), 64'(w_hold));
    end
  end

  task automatic drive(input bit st, input bit rst_v, input bit je, input bit ie,
                       input logic [CW-1:0] si, input logic [CW-1:0] sj,
                       input logic [DW-1:0] eta, input logic [DW-1:0] w, input logic [DW-1:0] d);
    int n;
    @(posedge CLK);
    #2;
    RST = rst_v; START = st; DATA_IN_J_ENABLE = je; DATA_IN_I_ENABLE = ie;
    SIZE_I_IN = si; SIZE_J_IN = sj; LEARNING_RATE_IN = eta; W_IN = w; D_IN = d;
    n = cyc;
    if (rst_v) begin
      for (int k = n; k < NCYC; k++) begin
        exp_vld[k] = 1'b0; exp_first[k] = 1'b0; exp_rdy[k] = 1'b0;
      end
      in_input  = 1'b0;
      idle_from = 0;
      return;
    end
    if (in_input && je) begin
      if (n + 2 < NCYC) begin
        exp_vld[n+2]   = 1'b1;
        exp_w[n+2]     = sgd_ref(w, d, eta_m);
        exp_first[n+2] = (idx % sj_m) == 0;
      end
      idx++;
      if (idx == total) begin
        in_input  = 1'b0;
        idle_from = n + 3;
        if (n + 3 < NCYC) exp_rdy[n+3] = 1'b1;
      end
    end
    if (st && !in_input && n >= idle_from) begin
      if (si == 0 || sj == 0) begin
        idle_from = n + 2;
        if (n + 2 < NCYC) exp_rdy[n+2] = 1'b1;
      end else begin
        in_input = 1'b1;
        idx      = 0;
        total    = int'(si) * int'(sj);
        sj_m     = int'(sj);
        eta_m    = eta;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    logic [DW-1:0] eta_r, w_r, d_r;
    logic [CW-1:0] si_r, sj_r;
    int guard;

    repeat (3) drive(0, 1, 0, 0, '0, '0, '0, '0, '0);
    idle(2);

    // 1x1: 1.0 - 0.5*2.0 = 0
    drive(1, 0, 0, 0, 1, 1, 32'h0000_8000, '0, '0);
    drive(0, 0, 1, 1, '0, '0, '0, 32'h0001_0000, 32'h0002_0000);
    idle(5);

    // 2x3 back-to-back: W=k, D=1, eta=1
    drive(1, 0, 0, 0, 2, 3, 32'h0001_0000, '0, '0);
    for (int k = 0; k < 6; k++) drive(0, 0, 1, (k % 3) == 0, '0, '0, '0, k << 16, 32'h0001_0000);
    idle(5);

    // Saturation both ways
    drive(1, 0, 0, 0, 1, 2, 32'h0001_0000, '0, '0);
    drive(0, 0, 1, 1, '0, '0, '0, 32'h7FFF_0000, 32'h8000_0000);
    drive(0, 0, 1, 0, '0, '0, '0, 32'h8000_0000, 32'h7FFF_FFFF);
    idle(5);

    // Floor rounding of a tiny negative product
    drive(1, 0, 0, 0, 1, 1, 32'h0000_0001, '0, '0);
    drive(0, 0, 1, 1, '0, '0, '0, '0, 32'hFFFF_FFFF);
    idle(5);

    // Zero size, then strobes while idle
    drive(1, 0, 0, 0, 3, 0, 32'h0001_0000, '0, '0);
    idle(1);
    repeat (4) drive(0, 0, 1, 1, '0, '0, '0, $urandom, $urandom);
    idle(3);

    // START during INPUT is ignored
    drive(1, 0, 0, 0, 2, 2, 32'h0001_0000, '0, '0);
    drive(0, 0, 1, 1, '0, '0, '0, 32'h0003_0000, 32'h0001_0000);
    drive(1, 0, 1, 0, 5, 5, 32'h0004_0000, 32'h0005_0000, 32'h0002_0000);
    drive(0, 0, 1, 1, '0, '0, '0, 32'h0007_0000, 32'hFFFF_0000);
    drive(1, 0, 1, 0, 1, 1, 32'h0004_0000, 32'h0009_0000, 32'h0000_8000);
    idle(5);

    // Reset after 3 of 6 elements, then a fresh job
    drive(1, 0, 0, 0, 2, 3, 32'h0001_0000, '0, '0);
    for (int k = 0; k < 3; k++) drive(0, 0, 1, k == 0, '0, '0, '0, (k + 10) << 16, 32'h0001_0000);
    drive(0, 1, 1, 0, '0, '0, '0, 32'h1234_0000, 32'h0001_0000);
    idle(3);
    drive(1, 0, 0, 0, 2, 3, 32'h0002_0000, '0, '0);
    for (int k = 0; k < 6; k++) drive(0, 0, 1, (k % 3) == 0, '0, '0, '0, (k + 20) << 16, 32'h0000_8000);
    idle(5);

    // Randomized jobs with gaps, noise strobes and stray STARTs
    for (int job = 0; job < 25; job++) begin
      si_r  = $urandom_range(0, 4);
      sj_r  = $urandom_range(1, 5);
      eta_r = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h0002_0000);
      drive(1, 0, $urandom_range(0, 1), 0, si_r, sj_r, eta_r, $urandom, $urandom);
      guard = 0;
      while (in_input && guard < 200) begin
        w_r = $urandom;
        d_r = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 32'h0004_0000);
        drive($urandom_range(0, 7) == 0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
              $urandom_range(1, 3), $urandom_range(1, 3), $urandom, w_r, d_r);
        guard++;
      end
      if (guard >= 200) check("job_timeout", 64'(guard), 64'(0));
      idle($urandom_range(0, 4));
    end
    idle(6);

    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
